// File: rtl/ifu_fetch_ctrl.sv
// rtl/ifu_fetch_ctrl.sv - IFU fetch controller: PC register, AXI4-Lite AR/R master, IDU valid/ready source
// One instruction in flight; the PC only moves on a WBU commit or on reset.

module ifu_fetch_ctrl #(
    parameter logic [31:0] RST_PC  = 32'h8000_0000,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc_i,
    input  logic        commit_i,
    output logic        arvalid_o,
    input  logic        arready_i,
    output logic [31:0] araddr_o,
    input  logic        rvalid_i,
    output logic        rready_o,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o
);

    typedef enum logic [1:0] {
        S_ADDR = 2'd0,
        S_DATA = 2'd1,
        S_HOLD = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_BUS     = 2'b01;
    localparam logic [1:0] CAUSE_MISALGN = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    // Expiry is detected on the last counted cycle so the fault lands after exactly TIMEOUT cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_inst;
    logic [31:0] w_inst_nxt;
    logic        r_fault;
    logic        w_fault_nxt;
    logic [1:0]  r_cause;
    logic [1:0]  w_cause_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic        r_started;

    logic        w_ar_hs;
    logic        w_expired;
    logic        w_bus_err;

    assign w_ar_hs   = arvalid_o & arready_i;
    assign w_expired = (r_cnt == CNT_LAST);
    assign w_bus_err = (rresp_i != 2'b00);

    // Keeps AR quiet for the settle edge that follows reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_ADDR;
            r_pc    <= RST_PC;
            r_inst  <= 32'h0;
            r_fault <= 1'b0;
            r_cause <= CAUSE_NONE;
            r_cnt   <= 8'h0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_inst  <= w_inst_nxt;
            r_fault <= w_fault_nxt;
            r_cause <= w_cause_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_inst_nxt  = r_inst;
        w_fault_nxt = r_fault;
        w_cause_nxt = r_cause;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            S_ADDR: begin
                if (r_started) begin
                    if (w_ar_hs) begin
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = 8'h0;
                    end else if (w_expired) begin
                        w_state_nxt = S_HOLD;
                        w_inst_nxt  = 32'h0;
                        w_fault_nxt = 1'b1;
                        w_cause_nxt = CAUSE_TIMEOUT;
                        w_cnt_nxt   = 8'h0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'h1;
                    end
                end
            end

            S_DATA: begin
                if (rvalid_i) begin
                    w_state_nxt = S_HOLD;
                    w_inst_nxt  = rdata_i;
                    w_fault_nxt = w_bus_err;
                    w_cause_nxt = w_bus_err ? CAUSE_BUS : CAUSE_NONE;
                    w_cnt_nxt   = 8'h0;
                end else if (w_expired) begin
                    // Abandoning the outstanding read is fatal; the core traps on this fault.
                    w_state_nxt = S_HOLD;
                    w_inst_nxt  = 32'h0;
                    w_fault_nxt = 1'b1;
                    w_cause_nxt = CAUSE_TIMEOUT;
                    w_cnt_nxt   = 8'h0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'h1;
                end
            end

            S_HOLD: begin
                if (ready_i) begin
                    w_state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                if (commit_i) begin
                    w_pc_nxt    = next_pc_i;
                    w_fault_nxt = 1'b0;
                    w_cause_nxt = CAUSE_NONE;
                    w_cnt_nxt   = 8'h0;
                    if (next_pc_i[1:0] == 2'b00) begin
                        w_state_nxt = S_ADDR;
                    end else begin
                        w_state_nxt = S_HOLD;
                        w_inst_nxt  = 32'h0;
                        w_fault_nxt = 1'b1;
                        w_cause_nxt = CAUSE_MISALGN;
                    end
                end
            end

            default: begin
                w_state_nxt = S_ADDR;
            end
        endcase
    end

    assign arvalid_o     = (r_state == S_ADDR) & r_started;
    assign rready_o      = (r_state == S_DATA);
    assign valid_o       = (r_state == S_HOLD);
    assign araddr_o      = r_pc;
    assign pc_o          = r_pc;
    assign inst_o        = r_inst;
    assign fault_o       = r_fault;
    assign fault_cause_o = r_cause;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb/tb_ifu_fetch_ctrl.sv - randomized bench for ifu_fetch_ctrl with a per-instruction transaction model
module tb_ifu_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          TO     = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] next_pc_i;
    logic        commit_i;
    logic        arvalid_o;
    logic        arready_i;
    logic [31:0] araddr_o;
    logic        rvalid_i;
    logic        rready_o;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        fault_o;
    logic [1:0]  fault_cause_o;

    ifu_fetch_ctrl #(.RST_PC(RST_PC), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .next_pc_i     (next_pc_i),
        .commit_i      (commit_i),
        .arvalid_o     (arvalid_o),
        .arready_i     (arready_i),
        .araddr_o      (araddr_o),
        .rvalid_i      (rvalid_i),
        .rready_o      (rready_o),
        .rdata_i       (rdata_i),
        .rresp_i       (rresp_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .fault_o       (fault_o),
        .fault_cause_o (fault_cause_o)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Expected architectural view of the instruction currently owned by the fetch unit.
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic        exp_fault;
    logic [1:0]  exp_cause;
    bit          start_hold;
    int          exp_ar_hs = 0;
    int          exp_r_hs  = 0;
    int          ar_hs     = 0;
    int          r_hs      = 0;

    always @(posedge clk) begin
        if (arvalid_o && arready_i) ar_hs <= ar_hs + 1;
        if (rready_o && rvalid_i)   r_hs  <= r_hs + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic noise_commit();
        commit_i  = 1'($urandom);
        next_pc_i = $urandom;
    endtask

    task automatic expect_timeout();
        exp_inst  = 32'h0;
        exp_fault = 1'b1;
        exp_cause = 2'b11;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_arvalid"}, arvalid_o, 0);
        check_eq({tag, "_rready"}, rready_o, 0);
        check_eq({tag, "_valid"}, valid_o, 0);
        check_eq({tag, "_araddr"}, araddr_o, RST_PC);
        check_eq({tag, "_pc"}, pc_o, RST_PC);
        check_eq({tag, "_inst"}, inst_o, 0);
        check_eq({tag, "_fault"}, fault_o, 0);
        check_eq({tag, "_cause"}, fault_cause_o, 0);
    endtask

    // One instruction: fetch (unless it starts already faulted in HOLD), present, retire, commit npc.
    task automatic run_instr(input int ar_wait, input int r_wait, input int idu_wait, input int wait_cyc,
                             input logic [31:0] rdata, input logic [1:0] rresp,
                             input logic [31:0] npc, input bit abort);
        int n;
        bit done;
        bit go_data;
        if (!start_hold) begin
            n = 0; done = 0; go_data = 0;
            while (!done) begin
                @(negedge clk);
                check_eq("addr_arvalid", arvalid_o, 1);
                check_eq("addr_araddr", araddr_o, exp_pc);
                check_eq("addr_rready", rready_o, 0);
                check_eq("addr_valid", valid_o, 0);
                noise_commit();
                rvalid_i = 1'b0;
                ready_i  = 1'($urandom);
                if (n >= ar_wait) begin
                    arready_i = 1'b1;
                    exp_ar_hs++;
                    go_data = 1; done = 1;
                end else begin
                    arready_i = 1'b0;
                    if (n == TO - 1) begin
                        expect_timeout();
                        done = 1;
                    end
                end
                n++;
            end
            if (go_data) begin
                n = 0; done = 0;
                while (!done) begin
                    @(negedge clk);
                    check_eq("data_rready", rready_o, 1);
                    check_eq("data_arvalid", arvalid_o, 0);
                    check_eq("data_valid", valid_o, 0);
                    check_eq("data_pc", pc_o, exp_pc);
                    noise_commit();
                    arready_i = 1'($urandom);
                    ready_i   = 1'($urandom);
                    rdata_i   = $urandom;
                    rresp_i   = 2'($urandom);
                    if (abort) begin
                        rvalid_i = 1'b0;
                        #3 rst = 1'b0;
                        #1 check_reset_values("abort");
                        @(negedge clk);
                        rst = 1'b1;
                        #1 check_eq("abort_settle_arvalid", arvalid_o, 0);
                        exp_pc = RST_PC;
                        start_hold = 0;
                        return;
                    end
                    if (n >= r_wait) begin
                        rvalid_i = 1'b1;
                        rdata_i  = rdata;
                        rresp_i  = rresp;
                        exp_r_hs++;
                        exp_inst  = rdata;
                        exp_fault = (rresp != 2'b00);
                        exp_cause = (rresp != 2'b00) ? 2'b01 : 2'b00;
                        done = 1;
                    end else begin
                        rvalid_i = 1'b0;
                        if (n == TO - 1) begin
                            expect_timeout();
                            done = 1;
                        end
                    end
                    n++;
                end
            end
        end
        n = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            check_eq("hold_valid", valid_o, 1);
            check_eq("hold_inst", inst_o, exp_inst);
            check_eq("hold_pc", pc_o, exp_pc);
            check_eq("hold_araddr", araddr_o, exp_pc);
            check_eq("hold_fault", fault_o, exp_fault);
            check_eq("hold_cause", fault_cause_o, exp_cause);
            check_eq("hold_arvalid", arvalid_o, 0);
            check_eq("hold_rready", rready_o, 0);
            noise_commit();
            arready_i = 1'($urandom);
            rvalid_i  = 1'($urandom);
            rdata_i   = $urandom;
            rresp_i   = 2'($urandom);
            ready_i   = (n >= idu_wait);
            done      = ready_i;
            n++;
        end
        for (int k = 0; k <= wait_cyc; k++) begin
            @(negedge clk);
            check_eq("wait_valid", valid_o, 0);
            check_eq("wait_arvalid", arvalid_o, 0);
            check_eq("wait_rready", rready_o, 0);
            check_eq("wait_pc", pc_o, exp_pc);
            arready_i = 1'($urandom);
            rvalid_i  = 1'($urandom);
            rdata_i   = $urandom;
            ready_i   = 1'($urandom);
            commit_i  = (k == wait_cyc);
            next_pc_i = (k == wait_cyc) ? npc : $urandom;
        end
        exp_pc    = npc;
        exp_fault = 1'b0;
        exp_cause = 2'b00;
        if (npc[1:0] != 2'b00) begin
            exp_inst   = 32'h0;
            exp_fault  = 1'b1;
            exp_cause  = 2'b10;
            start_hold = 1;
        end else begin
            start_hold = 0;
        end
    endtask

    initial begin
        logic [31:0] npc;
        logic [1:0]  rr;
        rst       = 1'b0;
        next_pc_i = 32'h0;
        commit_i  = 1'b0;
        arready_i = 1'b0;
        rvalid_i  = 1'b0;
        rdata_i   = 32'h0;
        rresp_i   = 2'b00;
        ready_i   = 1'b0;
        exp_pc    = RST_PC;
        exp_inst  = 32'h0;
        exp_fault = 1'b0;
        exp_cause = 2'b00;
        start_hold = 0;

        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
        #1 check_eq("settle_arvalid", arvalid_o, 0);

        run_instr(0, 0, 0, 1, 32'h0000_0413, 2'b00, 32'h8000_0004, 0);
        run_instr(3, 2, 4, 2, 32'h1234_5678, 2'b00, 32'h8000_0008, 0);
        run_instr(0, 1, 1, 0, 32'hDEAD_BEEF, 2'b10, 32'h8000_0102, 0);
        run_instr(0, 0, 2, 1, 32'h0, 2'b00, 32'h8000_0010, 0);
        run_instr(10, 0, 0, 0, 32'h0, 2'b00, 32'h8000_0020, 0);
        run_instr(0, 10, 1, 0, 32'h0, 2'b00, 32'h8000_0024, 0);
        run_instr(1, 5, 0, 0, 32'h0, 2'b00, 32'h0, 1);

        for (int i = 0; i < 80; i++) begin
            npc = $urandom;
            if ($urandom_range(0, 9) != 0) npc[1:0] = 2'b00;
            else if (npc[1:0] == 2'b00) npc[0] = 1'b1;
            rr = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_instr($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 4),
                      $urandom_range(0, 3), $urandom, rr, npc, 0);
        end

        @(negedge clk);
        check_eq("ar_handshakes", ar_hs, exp_ar_hs);
        check_eq("r_handshakes", r_hs, exp_r_hs);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
- Instruction-fetch controller of the IFU; holds the architectural PC and drives the AXI4-Lite AR/R channels to instruction memory.
- Presents the fetched instruction to the IDU over a valid/ready handshake.
- Loads the next PC from the next-PC mux on commit. araddr_o feeds that mux as the static-next-PC base.
- Multi-cycle, one instruction in flight at a time.

Parameters:
- RST_PC, 32'h8000_0000, PC value loaded at reset.
- TIMEOUT, 255, maximum cycles spent in ADDR or DATA before a bus-timeout fault; 8-bit counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- next_pc_i  input  32  next PC from the next-PC mux.
- commit_i  input  1  one-cycle pulse from WBU: current instruction retired, next_pc_i valid.
- arvalid_o  output  1  AXI AR valid.
- arready_i  input  1  AXI AR ready.
- araddr_o  output  32  AXI AR address; always equals the PC register.
- rvalid_i  input  1  AXI R valid.
- rready_o  output  1  AXI R ready.
- rdata_i  input  32  AXI R data.
- rresp_i  input  2  AXI R response; 2'b00 = OKAY.
- valid_o  output  1  instruction valid to IDU.
- ready_i  input  1  IDU ready.
- inst_o  output  32  fetched instruction.
- pc_o  output  32  PC of inst_o (equals araddr_o).
- fault_o  output  1  fetch fault flag, qualified by valid_o.
- fault_cause_o  output  2  fault cause: 01 bus error, 10 misaligned PC, 11 timeout; 00 when no fault.

Behaviour:
- States: ADDR, DATA, HOLD, WAIT. Encoding is free; outputs are registered or decoded from state only.
- Reset asserted (asynchronous):
  - state=ADDR, pc=RST_PC, inst=0, fault=0, cause=00, timeout counter=0.
  - arvalid_o=0 while rst=0; rready_o=0, valid_o=0.
- Reset deassertion: the first rising edge after deassertion is a settle cycle. arvalid_o rises one cycle after rst goes high (internal started flag, reset to 0).
- ADDR:
  - arvalid_o=1, araddr_o=pc, held stable until arready_i.
  - On arvalid_o & arready_i -> DATA, counter cleared.
- DATA:
  - rready_o=1.
  - On rvalid_i: inst<=rdata_i; if rresp_i!=00 then fault=1, cause=01. Then -> HOLD.
  - rvalid_i arriving in the same cycle as the AR handshake is not possible under AXI and is not supported.
- HOLD:
  - valid_o=1; inst_o, pc_o, fault_o and fault_cause_o are stable.
  - On valid_o & ready_i -> WAIT.
- WAIT:
  - All bus and IDU outputs are 0.
  - On commit_i:
    - pc<=next_pc_i; fault and cause are cleared.
    - If next_pc_i[1:0]==00 -> ADDR.
    - Otherwise no bus transaction is issued: inst<=32'h0, fault=1, cause=10 -> HOLD.
- commit_i in any state other than WAIT is ignored. It has no effect on pc or state.
- Timeout:
  - The counter increments each cycle in ADDR or DATA.
  - When it reaches TIMEOUT: fault=1, cause=11, inst=0 -> HOLD.
  - If the timeout fires in DATA, rready_o drops. A late R beat is then dropped, because rready_o=0 outside DATA.
  - The AXI protocol violation of abandoning an AR already issued is accepted as fatal. The core traps on the fault.
- Latency with zero-wait memory (arready_i and rvalid_i high):
  - AR handshake in cycle N.
  - Data captured at the end of N+1.
  - valid_o high in N+2.
- pc_o always equals araddr_o; both change only on reset or on commit_i in WAIT.
- Reset asserted in any state aborts immediately to the reset values. No outstanding AXI transaction is tracked across reset.

Test Plan:
- Reset then zero-wait memory returning rdata=32'h0000_0413:
  - araddr_o=32'h8000_0000 with arvalid_o=1 in the second cycle after rst rises.
  - valid_o=1 two cycles later with inst_o=32'h0000_0413, pc_o=32'h8000_0000, fault_o=0.
- Back-pressure: arready_i low 3 cycles, rvalid_i delayed 2 cycles, ready_i low 4 cycles -> araddr_o, inst_o and valid_o held stable throughout; exactly one AR handshake and one R handshake.
- Commit with next_pc_i=32'h8000_0004 -> next AR has araddr_o=32'h8000_0004. A commit_i pulse injected during DATA changes nothing.
- rresp_i=2'b10 with rdata=32'hDEAD_BEEF -> valid_o=1, fault_o=1, fault_cause_o=01, inst_o=32'hDEAD_BEEF; the next commit clears the fault.
- Misaligned redirect: commit with next_pc_i=32'h8000_0102 -> no arvalid_o; valid_o=1 next cycle with fault_cause_o=10, pc_o=32'h8000_0102.
- Timeout and abort:
  - TIMEOUT=4 with arready_i held at 0 -> fault_cause_o=11 after 4 ADDR cycles.
  - Separately, rst pulled low mid-DATA -> all outputs take reset values immediately, with no clock edge required.
